reg_writeback_queue: RTL and testbench

- Writeback-stage buffer directly upstream of the register file.
- Collects results from two producers, the ALU and the load unit. Queues them in program order and retires at most one per cycle onto the register file write port (wrtEn/wrtIndex/dataIn).
- Provides a youngest-match forwarding lookup over queued-but-unwritten results. Decode can then read correct operands while writes are still pending.

---
 rtl/reg_writeback_queue.sv | 101 ++++++++++
 tb/tb_reg_writeback_queue.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
// Writeback buffer ahead of the register file: merges ALU and load results in
// program order, retires one per cycle, and forwards the youngest queued value.
module reg_writeback_queue #(
  parameter int DEPTH           = 4,
  parameter int INDEX_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       aluValid,
  input  logic [INDEX_BIT_WIDTH-1:0] aluIndex,
  input  logic [DATA_BIT_WIDTH-1:0]  aluData,
  output logic                       aluReady,
  input  logic                       memValid,
  input  logic [INDEX_BIT_WIDTH-1:0] memIndex,
  input  logic [DATA_BIT_WIDTH-1:0]  memData,
  output logic                       memReady,
  output logic                       wrtEn,
  output logic [INDEX_BIT_WIDTH-1:0] wrtIndex,
  output logic [DATA_BIT_WIDTH-1:0]  dataOut,
  input  logic [INDEX_BIT_WIDTH-1:0] rdIndex1,
  input  logic [INDEX_BIT_WIDTH-1:0] rdIndex2,
  output logic                       fwdHit1,
  output logic                       fwdHit2,
  output logic [DATA_BIT_WIDTH-1:0]  fwdData1,
  output logic [DATA_BIT_WIDTH-1:0]  fwdData2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INDEX_BIT_WIDTH-1:0] idxMem  [DEPTH];
  logic [DATA_BIT_WIDTH-1:0]  dataMem [DEPTH];

  logic [PTR_W-1:0] head, tail, memSlot, scanPtr;
  logic [CNT_W-1:0] occ, free, numAcc;
  logic             deq, aluAcc, memAcc;

  assign count = occ;
  assign deq   = (occ != '0);

  // Free space counts the slot vacated this cycle, so ready never depends on valid-to-ready of itself
  assign free     = CNT_W'(DEPTH) - occ + CNT_W'(deq);
  assign aluReady = resetN & (free >= CNT_W'(1));
  assign memReady = resetN & (free >= (aluValid ? CNT_W'(2) : CNT_W'(1)));
  assign aluAcc   = aluValid & aluReady;
  assign memAcc   = memValid & memReady;
  assign numAcc   = CNT_W'(aluAcc) + CNT_W'(memAcc);
  assign memSlot  = aluAcc ? tail + PTR_W'(1) : tail;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head + PTR_W'(deq);
      tail <= tail + PTR_W'(numAcc);
      occ  <= occ + numAcc - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (aluAcc) begin
      idxMem[tail]  <= aluIndex;
      dataMem[tail] <= aluData;
    end
    if (memAcc) begin
      idxMem[memSlot]  <= memIndex;
      dataMem[memSlot] <= memData;
    end
  end

  assign wrtEn    = resetN & deq;
  assign wrtIndex = wrtEn ? idxMem[head]  : '0;
  assign dataOut  = wrtEn ? dataMem[head] : '0;

  // Walk oldest to youngest so the last match (youngest) wins
  always_comb begin
    fwdHit1  = 1'b0;
    fwdHit2  = 1'b0;
    fwdData1 = '0;
    fwdData2 = '0;
    scanPtr  = head;
    for (int i = 0; i < DEPTH; i++) begin
      scanPtr = head + PTR_W'(i);
      if (resetN && (CNT_W'(i) < occ)) begin
        if (idxMem[scanPtr] == rdIndex1) begin
          fwdHit1  = 1'b1;
          fwdData1 = dataMem[scanPtr];
        end
        if (idxMem[scanPtr] == rdIndex2) begin
          fwdHit2  = 1'b1;
          fwdData2 = dataMem[scanPtr];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue (DEPTH=4): ordering, backpressure,
// forwarding and reset behaviour against hand-computed expectations.
module tb_reg_writeback_queue;

  logic        clk = 1'b0;
  logic        resetN;
  logic        aluValid, memValid, aluReady, memReady;
  logic [3:0]  aluIndex, memIndex, wrtIndex, rdIndex1, rdIndex2;
  logic [31:0] aluData, memData, dataOut, fwdData1, fwdData2;
  logic        wrtEn, fwdHit1, fwdHit2;
  logic [2:0]  count;

  int checks = 0;
  int fails  = 0;

  reg_writeback_queue #(.DEPTH(4), .INDEX_BIT_WIDTH(4), .DATA_BIT_WIDTH(32)) dut (
    .clk(clk), .resetN(resetN),
    .aluValid(aluValid), .aluIndex(aluIndex), .aluData(aluData), .aluReady(aluReady),
    .memValid(memValid), .memIndex(memIndex), .memData(memData), .memReady(memReady),
    .wrtEn(wrtEn), .wrtIndex(wrtIndex), .dataOut(dataOut),
    .rdIndex1(rdIndex1), .rdIndex2(rdIndex2),
    .fwdHit1(fwdHit1), .fwdHit2(fwdHit2), .fwdData1(fwdData1), .fwdData2(fwdData2),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    aluValid = 1'b0; memValid = 1'b0;
    aluIndex = '0; memIndex = '0; aluData = '0; memData = '0;
  endtask

  task automatic test_reset();
    resetN = 1'b0; idle(); rdIndex1 = '0; rdIndex2 = '0;
    aluValid = 1'b1; aluIndex = 4'd1; aluData = 32'h55;
    tick(); tick();
    checks++; if (wrtEn !== 1'b0) begin fails++; $display("FAIL reset_wrtEn got %0b want 0", wrtEn); end
    checks++; if (aluReady !== 1'b0) begin fails++; $display("FAIL reset_aluReady got %0b want 0", aluReady); end
    checks++; if (memReady !== 1'b0) begin fails++; $display("FAIL reset_memReady got %0b want 0", memReady); end
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (fwdHit1 !== 1'b0 || dataOut !== 32'h0) begin fails++; $display("FAIL reset_outs got hit=%0b data=%h want 0", fwdHit1, dataOut); end
    idle(); resetN = 1'b1; #1;
    checks++; if (aluReady !== 1'b1 || memReady !== 1'b1) begin fails++; $display("FAIL release_ready got %0b%0b want 11", aluReady, memReady); end
    checks++; if (wrtEn !== 1'b0) begin fails++; $display("FAIL release_wrtEn got %0b want 0", wrtEn); end
  endtask

  task automatic test_single();
    aluValid = 1'b1; aluIndex = 4'd3; aluData = 32'hDEADBEEF;
    tick(); idle(); #1;
    checks++; if (wrtEn !== 1'b1 || wrtIndex !== 4'd3 || dataOut !== 32'hDEADBEEF)
      begin fails++; $display("FAIL single_write got en=%0b idx=%0d data=%h want 1 3 deadbeef", wrtEn, wrtIndex, dataOut); end
    checks++; if (count !== 3'd1) begin fails++; $display("FAIL single_count got %0d want 1", count); end
    tick();
    checks++; if (wrtEn !== 1'b0 || count !== 3'd0 || dataOut !== 32'h0 || wrtIndex !== 4'd0)
      begin fails++; $display("FAIL single_drain got en=%0b cnt=%0d data=%h want 0 0 0", wrtEn, count, dataOut); end
  endtask

  task automatic test_dual_order();
    aluValid = 1'b1; aluIndex = 4'd5; aluData = 32'h11;
    memValid = 1'b1; memIndex = 4'd5; memData = 32'h22;
    rdIndex1 = 4'd5; #1;
    checks++; if (memReady !== 1'b1) begin fails++; $display("FAIL dual_memReady got %0b want 1", memReady); end
    checks++; if (fwdHit1 !== 1'b0) begin fails++; $display("FAIL dual_no_fwd_incoming got %0b want 0", fwdHit1); end
    tick(); idle(); #1;
    checks++; if (wrtEn !== 1'b1 || wrtIndex !== 4'd5 || dataOut !== 32'h11 || count !== 3'd2)
      begin fails++; $display("FAIL dual_first got en=%0b idx=%0d data=%h cnt=%0d want 1 5 11 2", wrtEn, wrtIndex, dataOut, count); end
    checks++; if (fwdHit1 !== 1'b1 || fwdData1 !== 32'h22) begin fails++; $display("FAIL dual_fwd_young got hit=%0b data=%h want 1 22", fwdHit1, fwdData1); end
    tick();
    checks++; if (wrtEn !== 1'b1 || wrtIndex !== 4'd5 || dataOut !== 32'h22 || count !== 3'd1)
      begin fails++; $display("FAIL dual_second got en=%0b idx=%0d data=%h cnt=%0d want 1 5 22 1", wrtEn, wrtIndex, dataOut, count); end
    checks++; if (fwdHit1 !== 1'b1 || fwdData1 !== 32'h22) begin fails++; $display("FAIL dual_fwd_head got hit=%0b data=%h want 1 22", fwdHit1, fwdData1); end
    tick();
    checks++; if (fwdHit1 !== 1'b0 || fwdData1 !== 32'h0 || count !== 3'd0)
      begin fails++; $display("FAIL dual_empty got hit=%0b data=%h cnt=%0d want 0 0 0", fwdHit1, fwdData1, count); end
    rdIndex1 = '0;
  endtask

  task automatic test_fill_full();
    logic [31:0] seqD [8];
    logic [3:0]  seqI [8];
    logic [2:0]  expCnt [9];
    logic        expMem [5];
    seqD = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2, 32'hA3, 32'hA4};
    seqI = '{4'd0, 4'd8, 4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd4};
    expCnt = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1};
    expMem = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 9; c++) begin
      if (c < 5) begin
        aluValid = 1'b1; aluIndex = 4'(c);     aluData = 32'hA0 + 32'(c);
        memValid = 1'b1; memIndex = 4'(8 + c); memData = 32'hB0 + 32'(c);
      end else idle();
      #1;
      checks++; if (count !== expCnt[c]) begin fails++; $display("FAIL fill_count c=%0d got %0d want %0d", c, count, expCnt[c]); end
      if (c < 5) begin
        checks++; if (aluReady !== 1'b1 || memReady !== expMem[c])
          begin fails++; $display("FAIL fill_ready c=%0d got %0b%0b want 1%0b", c, aluReady, memReady, expMem[c]); end
      end
      if (c >= 1) begin
        checks++; if (wrtEn !== 1'b1 || wrtIndex !== seqI[c-1] || dataOut !== seqD[c-1])
          begin fails++; $display("FAIL fill_write c=%0d got en=%0b idx=%0d data=%h want 1 %0d %h", c, wrtEn, wrtIndex, dataOut, seqI[c-1], seqD[c-1]); end
      end
      tick();
    end
    checks++; if (count !== 3'd0 || wrtEn !== 1'b0) begin fails++; $display("FAIL fill_drained got cnt=%0d en=%0b want 0 0", count, wrtEn); end
  endtask

  task automatic test_forwarding();
    aluValid = 1'b1; aluIndex = 4'd1; aluData = 32'h1;
    memValid = 1'b1; memIndex = 4'd7; memData = 32'hA;
    tick();
    aluIndex = 4'd2; aluData = 32'hB;
    memIndex = 4'd7; memData = 32'hC;
    rdIndex1 = 4'd7; #1;
    checks++; if (fwdHit1 !== 1'b1 || fwdData1 !== 32'hA)
      begin fails++; $display("FAIL fwd_registered_only got hit=%0b data=%h want 1 a", fwdHit1, fwdData1); end
    tick(); idle();
    rdIndex1 = 4'd7; rdIndex2 = 4'd9; #1;
    checks++; if (count !== 3'd3) begin fails++; $display("FAIL fwd_count got %0d want 3", count); end
    checks++; if (fwdHit1 !== 1'b1 || fwdData1 !== 32'hC) begin fails++; $display("FAIL fwd_youngest got hit=%0b data=%h want 1 c", fwdHit1, fwdData1); end
    checks++; if (fwdHit2 !== 1'b0 || fwdData2 !== 32'h0) begin fails++; $display("FAIL fwd_miss got hit=%0b data=%h want 0 0", fwdHit2, fwdData2); end
    checks++; if (wrtIndex !== 4'd7 || dataOut !== 32'hA) begin fails++; $display("FAIL fwd_head_write got idx=%0d data=%h want 7 a", wrtIndex, dataOut); end
    tick();
    rdIndex2 = 4'd2; #1;
    checks++; if (fwdHit2 !== 1'b1 || fwdData2 !== 32'hB) begin fails++; $display("FAIL fwd_head_match got hit=%0b data=%h want 1 b", fwdHit2, fwdData2); end
    tick(); tick();
    checks++; if (count !== 3'd0 || fwdHit1 !== 1'b0) begin fails++; $display("FAIL fwd_drain got cnt=%0d hit=%0b want 0 0", count, fwdHit1); end
    rdIndex1 = '0; rdIndex2 = '0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    aluValid = 1'b1; aluIndex = 4'd6; aluData = 32'h61;
    memValid = 1'b1; memIndex = 4'd6; memData = 32'h62;
    tick();
    aluData = 32'h63; memData = 32'h64;
    tick(); idle(); #1;
    checks++; if (count !== 3'd3) begin fails++; $display("FAIL mid_setup_count got %0d want 3", count); end
    resetN = 1'b0;
    tick();
    checks++; if (count !== 3'd0 || wrtEn !== 1'b0) begin fails++; $display("FAIL mid_reset got cnt=%0d en=%0b want 0 0", count, wrtEn); end
    resetN = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      #1; if (wrtEn === 1'b1) pulses++;
      tick();
    end
    checks++; if (pulses !== 0) begin fails++; $display("FAIL mid_no_writes got %0d pulses want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual_order();
    test_fill_full();
    test_forwarding();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
